// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - phase, beat and round-key sequencer for the byte-serial AES datapath
// Drives the datapath strobes for AES-128/192/256 encrypt/decrypt; holds no data.
module aes_round_sequencer #(
  parameter int NK  = 4,
  parameter int BPC = 1,
  parameter int BW  = ((16 / BPC) > 1) ? $clog2(16 / BPC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic          in_key_new,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          inv,
  output logic          op_load,
  output logic          op_addkey,
  output logic          op_sub,
  output logic          op_shift,
  output logic          op_mix,
  output logic [BW-1:0] beat_idx,
  output logic [3:0]    round_idx,
  output logic          key_wr,
  output logic [5:0]    key_word_idx
);

  localparam int NR    = NK + 6;
  localparam int BEATS = 16 / BPC;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    NR_IDX    = 4'(NR);
  localparam logic [5:0]    LAST_KW   = 6'(4 * NR + 3);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_round_sequencer: NK must be 4, 6 or 8");
  end
  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("aes_round_sequencer: BPC must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_LOAD, S_ADDKEY, S_SUB, S_SHIFT, S_MIX, S_OUT
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] beat_n;
  logic [3:0]    round_n;
  logic [5:0]    kw_n;
  logic          inv_n;
  logic          last_beat;

  assign last_beat = (beat_idx == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      beat_idx     <= '0;
      round_idx    <= '0;
      key_word_idx <= '0;
      inv          <= 1'b0;
    end else begin
      state        <= state_n;
      beat_idx     <= beat_n;
      round_idx    <= round_n;
      key_word_idx <= kw_n;
      inv          <= inv_n;
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat_idx;
    round_n = round_idx;
    kw_n    = key_word_idx;
    inv_n   = inv;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          inv_n   = in_inv;
          round_n = in_inv ? NR_IDX : 4'd0;
          beat_n  = '0;
          kw_n    = '0;
          state_n = in_key_new ? S_KEYEXP : S_LOAD;
        end
      end
      S_KEYEXP: begin
        if (key_word_idx == LAST_KW) begin
          kw_n    = '0;
          state_n = S_LOAD;
        end else begin
          kw_n = key_word_idx + 6'd1;
        end
      end
      S_LOAD: begin
        if (last_beat) begin
          beat_n  = '0;
          state_n = S_ADDKEY;
        end else begin
          beat_n = beat_idx + BW'(1);
        end
      end
      S_ADDKEY: begin
        if (!last_beat) begin
          beat_n = beat_idx + BW'(1);
        end else begin
          beat_n = '0;
          if (!inv) begin
            if (round_idx == NR_IDX) begin
              state_n = S_OUT;
            end else begin
              state_n = S_SUB;
              round_n = round_idx + 4'd1;
            end
          end else if (round_idx == NR_IDX) begin
            // Final encrypt round has no MixColumns, so its inverse skips InvMixColumns too.
            state_n = S_SHIFT;
            round_n = round_idx - 4'd1;
          end else if (round_idx == 4'd0) begin
            state_n = S_OUT;
          end else begin
            state_n = S_MIX;
          end
        end
      end
      S_SUB: begin
        if (last_beat) begin
          beat_n  = '0;
          state_n = inv ? S_ADDKEY : S_SHIFT;
        end else begin
          beat_n = beat_idx + BW'(1);
        end
      end
      S_SHIFT: begin
        if (inv) begin
          state_n = S_SUB;
        end else begin
          state_n = (round_idx == NR_IDX) ? S_ADDKEY : S_MIX;
        end
      end
      S_MIX: begin
        if (last_beat) begin
          beat_n = '0;
          if (inv) begin
            state_n = S_SHIFT;
            round_n = round_idx - 4'd1;
          end else begin
            state_n = S_ADDKEY;
          end
        end else begin
          beat_n = beat_idx + BW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    // Abort wins over every transition above, including the OUT handshake.
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      beat_n  = '0;
      round_n = '0;
      kw_n    = '0;
      inv_n   = 1'b0;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign key_wr    = (state == S_KEYEXP);
  assign op_load   = (state == S_LOAD);
  assign op_addkey = (state == S_ADDKEY);
  assign op_sub    = (state == S_SUB);
  assign op_shift  = (state == S_SHIFT);
  assign op_mix    = (state == S_MIX);

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Parametrised control sequencer for the byte-serial AES core. It generalises the fixed AES-128 encrypt-only controller to AES-128/192/256, encrypt and decrypt, and 1–16 bytes per cycle. It adds a valid/ready block handshake, an optional round-key expansion pre-pass and a synchronous abort. The block drives the datapath phase strobes (load, AddRoundKey, (Inv)SubBytes, (Inv)ShiftRows, (Inv)MixColumns), the beat index and the round-key index; it holds no data itself.

## Interface
Parameters:
- NK, 4: key length in 32-bit words; legal values 4, 6, 8. NR = NK+6 rounds.
- BPC, 1: bytes processed per cycle; legal values 1, 2, 4, 8, 16. BEATS = 16/BPC.
- BW, max(1,log2(BEATS)): beat index width (derived).

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  block request
- in_ready  out  1  high only in IDLE
- in_inv  in  1  mode, sampled on accept; 0 = encrypt, 1 = decrypt
- in_key_new  in  1  sampled on accept; 1 = run key expansion first
- abort  in  1  synchronous abort
- out_valid  out  1  result ready in the datapath state register
- out_ready  in  1  consumer accepts the result
- busy  out  1  high in any state except IDLE
- inv  out  1  latched mode
- op_load, op_addkey, op_sub, op_shift, op_mix  out  1 each  phase strobes; at most one high
- beat_idx  out  BW  byte-group index within the current phase
- round_idx  out  4  round-key index used by AddRoundKey
- key_wr  out  1  expanded-key word write enable
- key_word_idx  out  6  expanded-key word index, 0..4*NR+3

## Operation
- States: IDLE, KEYEXP, LOAD, ADDKEY, SUB, SHIFT, MIX, OUT.
- Illegal NK or BPC stops elaboration with an error.
- **IDLE**
  - On in_valid & in_ready, latch the mode and go to KEYEXP if in_key_new, else LOAD.
  - Encrypt: round_idx ← 0. Decrypt: round_idx ← NR.
- **KEYEXP:** 4*(NR+1) cycles. key_wr = 1. key_word_idx counts from 0 to 4*NR+3. Then go to LOAD.
- **LOAD, ADDKEY, SUB, MIX:** each lasts BEATS cycles. beat_idx counts 0..BEATS-1 and resets to 0 on exit.
- **SHIFT:** lasts 1 cycle. beat_idx = 0.
- **Encrypt flow:** LOAD → ADDKEY.
  - ADDKEY with round_idx = NR → OUT. Otherwise → SUB, and round_idx increments on that transition.
  - SUB → SHIFT.
  - SHIFT → ADDKEY if round_idx = NR, else MIX.
  - MIX → ADDKEY.
- **Decrypt flow:** LOAD → ADDKEY (key NR).
  - ADDKEY with round_idx = NR → SHIFT, with round_idx decrementing.
  - ADDKEY with round_idx = 0 → OUT.
  - Any other ADDKEY → MIX.
  - MIX → SHIFT, with round_idx decrementing.
  - SHIFT → SUB → ADDKEY.
- **OUT:** out_valid = 1 and holds until out_ready; then go to IDLE. round_idx and inv keep their values in OUT.
- **abort:** valid in any non-IDLE state. The next state is IDLE with all counters cleared, and out_valid is never raised. abort takes priority over out_ready in OUT.
- in_valid while busy is ignored and has no side effects.

## Timing
- Reset values:
  - state IDLE; in_ready = 1.
  - All other outputs 0: busy, out_valid, inv, every op_*, key_wr, beat_idx, round_idx, key_word_idx.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- Accept happens in cycle T. The first busy cycle is T+1.
- Processing latency from T+1 to the first out_valid cycle:
  - L = BEATS*(3*NR+1) + NR.
  - Add 4*(NR+1) when in_key_new = 1.
  - Decrypt latency equals encrypt latency.
- A new block can be accepted on the cycle after the out_valid & out_ready handshake.
- Reset asserted mid-operation returns the block to reset values immediately (asynchronous). The first accept is possible on the first clock after release.

## Test plan
- **NK=4, BPC=1, encrypt, key_new=0, out_ready=1.**
  - out_valid first high at T+507.
  - Exactly 11 ADDKEY phases, 9 MIX phases, 10 SHIFT cycles.
  - round_idx sequence at each ADDKEY is 0..10.
- **NK=8, BPC=4, decrypt, key_new=1.**
  - 60 key_wr cycles with key_word_idx 0..59.
  - Then out_valid at T+1+60+(4*43+14) = T+247.
  - round_idx at each ADDKEY is 14, 13 … 0.
  - No MIX phase between ADDKEY(14) and the following SHIFT.
- **NK=6, BPC=16, encrypt, out_ready held low for 20 cycles.**
  - out_valid at T+1+(37+12) = T+50.
  - out_valid holds, with op_* all 0 and in_ready = 0, until out_ready goes high; then IDLE on the next cycle.
- **abort during the 3rd SUB phase.**
  - IDLE next cycle; busy, op_* and beat_idx all 0.
  - out_valid never rises.
  - A new request 1 cycle later is accepted normally.
- **rst pulsed low during MIX.**
  - All outputs go to reset values in the same cycle, without waiting for a clock edge.
  - in_valid held high throughout is accepted on the first clock after release.
- **Mutual exclusion check, all parameter combinations:** at most one op_* is high in every cycle; beat_idx ≤ BEATS-1; in_valid pulses while busy cause no state change.
